// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
// The CSUM state is always declared; it is only reachable when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        RUN,
        ERR
    } loaderStateT;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/ins_word_assembler.sv
// Packs accepted payload bytes MSB-first into 32-bit words.
// The running XOR of payload bytes exists only when LOADER_CHECKSUM_EN is defined.
module ins_word_assembler
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_wordDone
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  o_xor
`endif
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] r_byteIdx;
    logic [23:0]      r_shift;

    // Only the first three bytes are staged; the fourth is combined directly
    // so the finished word is available in the cycle its last byte arrives.
    assign o_wordDone = i_valid && (r_byteIdx == IDX_W'(BYTES_PER_WORD - 1));
    assign o_word     = {r_shift, i_byte};

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_byteIdx <= '0;
            r_shift   <= '0;
        end else if (i_valid) begin
            r_byteIdx <= r_byteIdx + IDX_W'(1);
            r_shift   <= {r_shift[15:0], i_byte};
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    assign o_xor = r_xor;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_xor <= '0;
        end else if (i_valid) begin
            r_xor <= r_xor ^ i_byte;
        end
    end
`endif

endmodule

// File: rtl/ins_loader.sv
// Byte-stream program loader feeding instruction memory; holds the core in reset until loaded.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module ins_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        LOAD,
    output logic [31:0] W_Ins,
    output logic        WE,
    output logic [31:0] W_Addr,
    output logic        CPU_RST,
    output logic        DONE,
    output logic        ERROR,
    output logic [15:0] LOADED
);

    localparam int IDXW = $clog2(MAX_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
    localparam loaderStateT PAYLOAD_END = CSUM;
`else
    localparam loaderStateT PAYLOAD_END = RUN;
`endif

    loaderStateT     r_state;
    loaderStateT     w_stateNext;
    logic [7:0]      r_nHi;
    logic [15:0]     r_n;
    logic [IDXW-1:0] r_wordIdx;
    logic [IDXW-1:0] w_idxNext;
    logic [31:0]     r_wIns;
    logic [31:0]     r_wAddr;
    logic            r_we;

    logic            w_inReady;
    logic            w_xfer;
    logic            w_restart;
    logic            w_asmValid;
    logic [15:0]     w_nFull;
    logic [31:0]     w_word;
    logic            w_wordDone;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      w_xor;
`endif

    assign w_inReady  = !RST && ((r_state == HDR_HI) || (r_state == HDR_LO) ||
                                 (r_state == DATA)   || (r_state == CSUM));
    assign w_xfer     = in_valid && w_inReady;
    assign w_asmValid = w_xfer && (r_state == DATA);
    assign w_nFull    = {r_nHi, in_data};
    assign w_idxNext  = r_wordIdx + IDXW'(1);

    ins_word_assembler u_assembler (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_clear    (w_restart),
        .i_valid    (w_asmValid),
        .i_byte     (in_data),
        .o_word     (w_word),
        .o_wordDone (w_wordDone)
`ifdef LOADER_CHECKSUM_EN
        ,
        .o_xor      (w_xor)
`endif
    );

    always_comb begin
        w_stateNext = r_state;
        w_restart   = 1'b0;
        case (r_state)
            HDR_HI: begin
                if (w_xfer) w_stateNext = HDR_LO;
            end
            HDR_LO: begin
                if (w_xfer) begin
                    if (32'(w_nFull) > MAX_WORDS) w_stateNext = ERR;
                    else if (w_nFull == 16'd0)    w_stateNext = PAYLOAD_END;
                    else                          w_stateNext = DATA;
                end
            end
            DATA: begin
                if (w_wordDone && (16'(w_idxNext) == r_n)) w_stateNext = PAYLOAD_END;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_xfer) w_stateNext = (in_data == w_xor) ? RUN : ERR;
            end
`endif
            RUN, ERR: begin
                if (LOAD) begin
                    w_restart   = 1'b1;
                    w_stateNext = HDR_HI;
                end
            end
            default: w_stateNext = HDR_HI;
        endcase
    end

    // WE is delayed one cycle behind the completing byte, so the address
    // captured here is the index before it advances.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= HDR_HI;
            r_nHi     <= '0;
            r_n       <= '0;
            r_wordIdx <= '0;
            r_wIns    <= '0;
            r_wAddr   <= '0;
            r_we      <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_we    <= w_wordDone;
            if ((r_state == HDR_HI) && w_xfer) r_nHi <= in_data;
            if ((r_state == HDR_LO) && w_xfer) r_n   <= w_nFull;
            if (w_restart) begin
                r_wordIdx <= '0;
            end else if (w_wordDone) begin
                r_wordIdx <= w_idxNext;
                r_wIns    <= w_word;
                r_wAddr   <= 32'({r_wordIdx, 2'b00});
            end
        end
    end

    assign in_ready = w_inReady;
    assign W_Ins    = r_wIns;
    assign WE       = r_we;
    assign W_Addr   = r_wAddr;
    assign CPU_RST  = (r_state != RUN);
    assign DONE     = (r_state == RUN);
    assign ERROR    = (r_state == ERR);
    assign LOADED   = 16'(r_wordIdx);

endmodule
